jtopll_wrsched: RTL

//  Host-side register write scheduler for the jtopll sound core. Queues (register,value)

---
 rtl/jtopll_wrsched.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/jtopll_wrsched.sv
// ============================================================================
// jtopll_wrsched : queued host register-write scheduler driving the jtopll bus
// Optional feature macro: JTOPLL_WRSCHED_SKIP_EN (skip repeated address phase)
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtopll_wrsched #(
    parameter int AW       = 4,
    parameter int WR_PULSE = 2,
    parameter int ADDR_GAP = 12,
    parameter int DATA_GAP = 84
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [7:0]    req_reg,
    input  logic [7:0]    req_val,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          opl_addr,
    output logic [7:0]    opl_din,
    output logic          opl_cs_n,
    output logic          opl_wr_n
);

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_AWR    = 3'd1;
    localparam logic [2:0]  c_ST_AGAP   = 3'd2;
    localparam logic [2:0]  c_ST_DWR    = 3'd3;
    localparam logic [2:0]  c_ST_DGAP   = 3'd4;

    localparam logic [AW:0] c_FULL      = {1'b1, {AW{1'b0}}};
    localparam logic [7:0]  c_PULSE_END = 8'(WR_PULSE - 1);
    localparam logic [7:0]  c_AGAP_END  = 8'(ADDR_GAP - 1);
    localparam logic [7:0]  c_DGAP_END  = 8'(DATA_GAP - 1);

    logic [15:0]   mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;

    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    hreg_q, hreg_d;
    logic [7:0]    hval_q, hval_d;

    logic          addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;

    logic          w_push, w_pop, w_skip;
    logic [15:0]   w_head;

    assign req_ready = (level_q != c_FULL);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = cen & (state_q == c_ST_IDLE) & (level_q != '0);
    assign w_head    = mem_q[rd_ptr_q];

    assign level     = level_q;
    assign busy      = (level_q != '0) | (state_q != c_ST_IDLE);
    assign opl_addr  = addr_q;
    assign opl_din   = din_q;
    assign opl_cs_n  = cs_n_q;
    assign opl_wr_n  = wr_n_q;

    // Queue storage needs no reset: only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {req_reg, req_val};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef JTOPLL_WRSCHED_SKIP_EN
    logic [7:0] last_reg_q;
    logic       last_ok_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg_q <= '0;
            last_ok_q  <= 1'b0;
        end else if (cen && (state_q == c_ST_AWR) && (cnt_q == c_PULSE_END)) begin
            last_reg_q <= hreg_q;
            last_ok_q  <= 1'b1;
        end
    end

    assign w_skip = last_ok_q & (w_head[15:8] == last_reg_q);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hreg_d  = hreg_q;
        hval_d  = hval_q;
        case (state_q)
            c_ST_IDLE: begin
                if (level_q != '0) begin
                    hreg_d  = w_head[15:8];
                    hval_d  = w_head[7:0];
                    cnt_d   = '0;
                    state_d = w_skip ? c_ST_DWR : c_ST_AWR;
                end
            end
            c_ST_AWR: begin
                if (cnt_q == c_PULSE_END) begin
                    state_d = c_ST_AGAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_ST_AGAP: begin
                if (cnt_q == c_AGAP_END) begin
                    state_d = c_ST_DWR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_ST_DWR: begin
                if (cnt_q == c_PULSE_END) begin
                    state_d = c_ST_DGAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_ST_DGAP: begin
                if (cnt_q == c_DGAP_END) begin
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus pins are a registered decode of the current state, so they trail it by one cen.
    always_comb begin
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        addr_d = addr_q;
        din_d  = din_q;
        if (state_q == c_ST_AWR) begin
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            addr_d = 1'b0;
            din_d  = hreg_q;
        end else if (state_q == c_ST_DWR) begin
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            addr_d = 1'b1;
            din_d  = hval_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            hreg_q  <= '0;
            hval_q  <= '0;
            addr_q  <= 1'b0;
            din_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else if (cen) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hreg_q  <= hreg_d;
            hval_q  <= hval_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

endmodule

`default_nettype wire
